wb_select_pipe: RTL and testbench

//   Parametrised write-back stage for the pipelined datapath. Selects one of NSRC

---
 rtl/wb_select_pipe.sv | 96 +++++++++
 tb/tb_wb_select_pipe.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_select_pipe.sv
// rtl/wb_select_pipe.sv - write-back source/destination select behind a one-entry valid/ready stage
// Traps illegal selects, suppresses $0 writes and counts retired register writes.
module wb_select_pipe #(
   parameter int DATA_W   = 32,
   parameter int NSRC     = 4,
   parameter int SEL_W    = 2,
   parameter int REG_AW   = 5,
   parameter int LINK_REG = 31,
   parameter int CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [NSRC*DATA_W-1:0] src_data,
   input  logic [SEL_W-1:0]       data_sel,
   input  logic [1:0]             dst_sel,
   input  logic [REG_AW-1:0]      instr_rt,
   input  logic [REG_AW-1:0]      instr_rd,
   input  logic                   reg_write,
   input  logic                   flush,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      wb_data,
   output logic [REG_AW-1:0]      wb_addr,
   output logic                   wb_we,
   output logic                   sel_err,
   output logic [CNT_W-1:0]       wr_count
);

   logic [DATA_W-1:0] mux_data;
   logic              data_ok;
   logic [REG_AW-1:0] dst_addr;
   logic              dst_ok;
   logic              we_next;
   logic              we_q;
   logic              accept;
   logic              consume;

   // An out-of-range data_sel matches no source and leaves the zero default.
   always_comb begin
      mux_data = '0;
      data_ok  = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (data_sel == SEL_W'(i)) begin
            mux_data = src_data[i*DATA_W +: DATA_W];
            data_ok  = 1'b1;
         end
      end
   end

   always_comb begin
      dst_addr = '0;
      dst_ok   = 1'b1;
      case (dst_sel)
         2'b00:   dst_addr = instr_rt;
         2'b01:   dst_addr = instr_rd;
         2'b10:   dst_addr = REG_AW'(LINK_REG);
         default: dst_ok   = 1'b0;
      endcase
   end

   assign we_next  = reg_write & data_ok & dst_ok & (dst_addr != '0);
   assign in_ready = ~out_valid | out_ready;
   assign accept   = in_valid & in_ready & ~flush;
   assign consume  = out_valid & out_ready;
   assign wb_we    = out_valid & we_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         wb_data   <= '0;
         wb_addr   <= '0;
         we_q      <= 1'b0;
         sel_err   <= 1'b0;
         wr_count  <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (accept) begin
            out_valid <= 1'b1;
            wb_data   <= mux_data;
            wb_addr   <= dst_addr;
            we_q      <= we_next;
            if (!data_ok || !dst_ok)
               sel_err <= 1'b1;
         end else if (consume) begin
            out_valid <= 1'b0;
         end
         // A flushed entry is discarded, never retired.
         if (consume && wb_we && !flush)
            wr_count <= wr_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_wb_select_pipe.sv
// tb/tb_wb_select_pipe.sv - directed plus randomized checks of wb_select_pipe against a spec-level model
module tb_wb_select_pipe;
   localparam int DW = 32;
   localparam int NS = 3;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [NS*DW-1:0] src_data;
   logic [1:0]    data_sel;
   logic [1:0]    dst_sel;
   logic [4:0]    instr_rt;
   logic [4:0]    instr_rd;
   logic          reg_write;
   logic          flush;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] wb_data;
   logic [4:0]    wb_addr;
   logic          wb_we;
   logic          sel_err;
   logic [CW-1:0] wr_count;

   int vectors = 0;
   int miscompares = 0;

   bit          m_valid;
   logic [31:0] m_data;
   logic [4:0]  m_addr;
   bit          m_we;
   bit          m_err;
   int          m_count;

   always #5 clk = ~clk;

   wb_select_pipe #(
      .DATA_W(DW), .NSRC(NS), .SEL_W(2), .REG_AW(5), .LINK_REG(31), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .src_data(src_data), .data_sel(data_sel), .dst_sel(dst_sel),
      .instr_rt(instr_rt), .instr_rd(instr_rd), .reg_write(reg_write),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we),
      .sel_err(sel_err), .wr_count(wr_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 0; m_data = 0; m_addr = 0; m_we = 0; m_err = 0; m_count = 0;
   endtask

   // Spec-level effect of one clock edge given the current inputs.
   task automatic model_edge();
      bit acc, cons, legal_d, legal_a;
      acc  = in_valid && (!m_valid || out_ready) && !flush;
      cons = m_valid && out_ready;
      if (cons && m_we && !flush) m_count = (m_count + 1) % (1 << CW);
      if (flush) begin
         m_valid = 0;
      end else if (acc) begin
         legal_d = (int'(data_sel) < NS);
         legal_a = (dst_sel != 2'b11);
         m_data  = legal_d ? src_data[int'(data_sel)*DW +: DW] : 32'h0;
         case (dst_sel)
            2'b00:   m_addr = instr_rt;
            2'b01:   m_addr = instr_rd;
            2'b10:   m_addr = 5'd31;
            default: m_addr = 5'd0;
         endcase
         m_we = reg_write && legal_d && legal_a && (m_addr != 0);
         if (!legal_d || !legal_a) m_err = 1;
         m_valid = 1;
      end else if (cons) begin
         m_valid = 0;
      end
   endtask

   task automatic check_outputs(input string tag);
      chk({tag, ".valid"}, 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
         chk({tag, ".data"}, wb_data, m_data);
         chk({tag, ".addr"}, 32'(wb_addr), 32'(m_addr));
      end
      chk({tag, ".we"}, 32'(wb_we), 32'(m_valid && m_we));
      chk({tag, ".err"}, 32'(sel_err), 32'(m_err));
      chk({tag, ".cnt"}, 32'(wr_count), 32'(m_count));
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic cycle(input string tag);
      #1;
      chk({tag, ".rdy"}, 32'(in_ready), 32'(!m_valid || out_ready));
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic set_in(input bit v, input logic [1:0] ds, input logic [1:0] dst,
                         input logic [4:0] rt, input logic [4:0] rd, input bit rw);
      in_valid = v; data_sel = ds; dst_sel = dst; instr_rt = rt; instr_rd = rd; reg_write = rw;
   endtask

   initial begin
      int c0;
      rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; src_data = '0;
      set_in(0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      check_outputs("reset");
      chk("reset.data", wb_data, 32'h0);
      chk("reset.addr", 32'(wb_addr), 32'h0);
      chk("reset.rdy", 32'(in_ready), 32'h1);
      rst_n = 1'b1;

      // back-to-back
      src_data = {32'h33, 32'h22, 32'h11};
      out_ready = 1'b1;
      set_in(1, 0, 2'b01, 0, 8, 1); cycle("b2b0"); chk("b2b0.lit", wb_data, 32'h11);
      set_in(1, 1, 2'b01, 0, 8, 1); cycle("b2b1"); chk("b2b1.lit", wb_data, 32'h22);
      set_in(1, 2, 2'b01, 0, 8, 1); cycle("b2b2"); chk("b2b2.lit", wb_data, 32'h33);
      chk("b2b.addr", 32'(wb_addr), 32'd8);
      set_in(0, 0, 2'b01, 0, 8, 1); cycle("b2b_drain");
      chk("b2b.cnt3", 32'(wr_count), 32'd3);

      // stall
      out_ready = 1'b0;
      src_data = {32'hC3, 32'hB2, 32'hA1};
      set_in(1, 0, 2'b01, 0, 9, 1); cycle("stall_fill");
      set_in(1, 1, 2'b01, 0, 10, 1);
      for (int i = 0; i < 4; i++) begin
         cycle("stall");
         chk("stall.held", wb_data, 32'hA1);
      end
      out_ready = 1'b1;
      cycle("stall_rel"); chk("stall.next", wb_data, 32'hB2);
      set_in(0, 0, 0, 0, 0, 0); cycle("stall_drain");

      // link and $0
      set_in(1, 2, 2'b10, 0, 0, 1); cycle("link");
      chk("link.addr", 32'(wb_addr), 32'd31);
      chk("link.we", 32'(wb_we), 32'h1);
      c0 = m_count;
      set_in(1, 1, 2'b00, 0, 7, 1); cycle("zero");
      chk("zero.we", 32'(wb_we), 32'h0);
      set_in(0, 0, 0, 0, 0, 0); cycle("zero_drain");
      chk("zero.err", 32'(sel_err), 32'h0);
      chk("zero.cnt", 32'(wr_count), 32'((c0 + 1) % 4));

      // illegal selects
      set_in(1, 3, 2'b01, 0, 4, 1); cycle("ill_data");
      chk("ill.data0", wb_data, 32'h0);
      chk("ill.err", 32'(sel_err), 32'h1);
      set_in(1, 0, 2'b01, 0, 4, 1); cycle("ill_legal");
      set_in(1, 1, 2'b11, 3, 4, 1); cycle("ill_dst");
      chk("ill.addr0", 32'(wb_addr), 32'h0);
      chk("ill.we0", 32'(wb_we), 32'h0);
      chk("ill.sticky", 32'(sel_err), 32'h1);
      set_in(0, 0, 0, 0, 0, 0); cycle("ill_drain");

      // flush with a held entry and incoming data
      out_ready = 1'b0;
      set_in(1, 0, 2'b01, 0, 6, 1); cycle("fl_fill");
      c0 = m_count;
      flush = 1'b1; out_ready = 1'b1;
      set_in(1, 1, 2'b01, 0, 7, 1); cycle("flush");
      chk("flush.valid", 32'(out_valid), 32'h0);
      chk("flush.cnt", 32'(wr_count), 32'(c0));
      flush = 1'b0;

      // counter wrap
      c0 = m_count;
      for (int i = 0; i < 5; i++) begin
         set_in(1, 2'(i % 3), 2'b01, 0, 5, 1); cycle("wrap");
      end
      set_in(0, 0, 0, 0, 0, 0); cycle("wrap_drain");
      chk("wrap.cnt", 32'(wr_count), 32'((c0 + 5) % 4));

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         src_data  = {$urandom, $urandom, $urandom};
         in_valid  = $urandom_range(0, 3) != 0;
         out_ready = $urandom_range(0, 2) != 0;
         flush     = $urandom_range(0, 9) == 0;
         data_sel  = 2'($urandom_range(0, 3));
         dst_sel   = 2'($urandom_range(0, 3));
         instr_rt  = 5'($urandom_range(0, 7));
         instr_rd  = 5'($urandom_range(0, 31));
         reg_write = $urandom_range(0, 3) != 0;
         cycle("rand");
      end
      flush = 1'b0;

      // reset mid-stream between edges
      out_ready = 1'b0;
      set_in(1, 0, 2'b01, 0, 3, 1); cycle("mid_fill");
      chk("mid.pre", 32'(out_valid), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("mid_rst");
      chk("mid.data", wb_data, 32'h0);
      chk("mid.rdy", 32'(in_ready), 32'h1);
      #1 rst_n = 1'b1;
      set_in(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cycle("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
